// File: rtl/bf16_pkg.sv
// bf16_pkg: shared rounding-mode enum, fpcsr flag indices, BF16 constants and stage-1 beat layout
package bf16_pkg;
  typedef enum logic [2:0] {
    RM_RNE = 3'b000,
    RM_RTZ = 3'b001,
    RM_RDN = 3'b010,
    RM_RUP = 3'b011,
    RM_RMM = 3'b100
  } rm_e;
  localparam int FLAG_NX = 0;
  localparam int FLAG_UF = 1;
  localparam int FLAG_OF = 2;
  localparam int FLAG_NV = 3;
  localparam logic [15:0] BF16_QNAN = 16'h7FC0;
  localparam logic [15:0] BF16_POS_INF = 16'h7F80;
  localparam logic [14:0] BF16_MAX_FIN = 15'h7F7F;
  typedef struct packed {
    logic [15:0] hi;
    logic inc;
    logic nan;
    logic nv;
    logic ovf;
    logic nx;
    logic uf;
    logic ftz;
  } s1_t;
endpackage

// File: rtl/fp32_bf16_round.sv
// fp32_bf16_round: IEEE rounding increment decision from sign/lsb/guard/sticky
module fp32_bf16_round
  import bf16_pkg::*;
(
  input  logic       sign,
  input  logic       lsb,
  input  logic       guard,
  input  logic       sticky,
  input  logic [2:0] rm,
  output logic       inc,
  output logic       inexact
);
  // per-mode increment; unknown modes never reach here (mapped upstream)
  always_comb begin
    inexact = guard | sticky;
    inc = rm == RM_RNE ? guard & (sticky | lsb) :
          rm == RM_RDN ? sign & inexact :
          rm == RM_RUP ? ~sign & inexact :
          rm == RM_RMM ? guard : 1'b0;
  end
endmodule

// File: rtl/fp32_to_bf16.sv
// fp32_to_bf16: two-stage FP32->BF16 narrowing with rounding modes and sticky flags (FP32_BF16_FTZ_EN flushes subnormals)
module fp32_to_bf16
  import bf16_pkg::*;
#(
  parameter logic [2:0] RESET_RM = 3'b000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instruction_enable,
  output logic        in_ready,
  input  logic [31:0] operand_a,
  input  logic [2:0]  rm,
  output logic [15:0] result,
  output logic        result_valid,
  input  logic        result_ready,
  output logic [3:0]  fpcsr,
  input  logic        fpcsr_clear
);
  logic        s1_valid;
  logic        adv2;
  logic        special;
  logic        inc_r;
  logic        nx_r;
  logic [2:0]  rm_eff;
  logic [15:0] packed_res;
  logic [3:0]  flags;
  s1_t         s1;
  s1_t         s1_d;

  assign adv2 = ~result_valid | result_ready;
  assign in_ready = ~s1_valid | adv2;
  assign rm_eff = rm > 3'd4 ? RESET_RM : rm;

  fp32_bf16_round u_round (
    .sign    (operand_a[31]),
    .lsb     (operand_a[16]),
    .guard   (operand_a[15]),
    .sticky  (|operand_a[14:0]),
    .rm      (rm_eff),
    .inc     (inc_r),
    .inexact (nx_r)
  );

  // classify the operand and settle the rounding decision; overflow is flagged
  // whenever the value rounds up or lies at/above the halfway point past max finite
  always_comb begin
    special = &operand_a[30:23];
    s1_d.hi = operand_a[31:16];
    s1_d.nan = special & |operand_a[22:0];
    s1_d.nv = s1_d.nan & ~operand_a[22];
`ifdef FP32_BF16_FTZ_EN
    s1_d.ftz = ~|operand_a[30:23] & |operand_a[22:0];
`else
    s1_d.ftz = 1'b0;
`endif
    s1_d.inc = ~special & ~s1_d.ftz & inc_r;
    s1_d.ovf = ~special & operand_a[30:16] == BF16_MAX_FIN & (inc_r | operand_a[15]);
    s1_d.nx = ~special & (s1_d.ftz | nx_r);
    s1_d.uf = s1_d.ftz | (~|operand_a[30:23] & nx_r);
  end

  // pack the stage-1 decision into the BF16 encoding and its flag vector
  always_comb begin
    packed_res = s1.nan ? BF16_QNAN :
                 s1.ftz ? {s1.hi[15], 15'h0} :
                 s1.ovf ? {s1.hi[15], s1.inc ? BF16_POS_INF[14:0] : BF16_MAX_FIN} :
                 s1.hi + {15'h0, s1.inc};
    flags = '0;
    flags[FLAG_NX] = s1.nx;
    flags[FLAG_UF] = s1.uf;
    flags[FLAG_OF] = s1.ovf;
    flags[FLAG_NV] = s1.nv;
  end

  // stage 1 register: accepts a new operand whenever it can drain
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      s1_valid <= 1'b0;
      s1 <= '0;
    end else if (in_ready) begin
      s1_valid <= instruction_enable;
      if (instruction_enable) s1 <= s1_d;
    end

  // stage 2 register: holds result steady while the consumer stalls
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      result_valid <= 1'b0;
      result <= 16'h0000;
    end else if (adv2) begin
      result_valid <= s1_valid;
      if (s1_valid) result <= packed_res;
    end

  // sticky flags; a clear wins over a beat entering stage 2 in the same cycle
  always_ff @(posedge clk or negedge reset)
    if (!reset) fpcsr <= 4'h0;
    else if (fpcsr_clear) fpcsr <= 4'h0;
    else if (s1_valid & adv2) fpcsr <= fpcsr | flags;
endmodule

// File: tb/tb_fp32_to_bf16.sv
// tb_fp32_to_bf16: directed and randomized checks of fp32_to_bf16 against a behavioural model
module tb_fp32_to_bf16;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        instruction_enable = 1'b0;
  logic        in_ready;
  logic [31:0] operand_a = '0;
  logic [2:0]  rm = '0;
  logic [15:0] result;
  logic        result_valid;
  logic        result_ready = 1'b1;
  logic [3:0]  fpcsr;
  logic        fpcsr_clear = 1'b0;
  int          checks = 0;
  int          errors = 0;
  logic [3:0]  csr_m = '0;

  always #5 clk = ~clk;

  fp32_to_bf16 dut (
    .clk                (clk),
    .reset              (reset),
    .instruction_enable (instruction_enable),
    .in_ready           (in_ready),
    .operand_a          (operand_a),
    .rm                 (rm),
    .result             (result),
    .result_valid       (result_valid),
    .result_ready       (result_ready),
    .fpcsr              (fpcsr),
    .fpcsr_clear        (fpcsr_clear)
  );

  // returns {flags[3:0], bf16[15:0]} from the value split into kept half and discarded half
  function automatic logic [19:0] model(input logic [31:0] op, input logic [2:0] mode);
    logic [2:0]  m;
    logic        s;
    logic [7:0]  e;
    logic [15:0] t;
    logic [15:0] r;
    logic        up;
    m = mode > 3'd4 ? 3'd0 : mode;
    s = op[31];
    e = op[30:23];
    t = op[31:16];
    r = op[15:0];
    if (e == 8'hFF) return op[22:0] != 0 ? {(op[22] ? 4'h0 : 4'h8), 16'h7FC0} : {4'h0, t};
`ifdef FP32_BF16_FTZ_EN
    if (e == 8'h00 && op[22:0] != 0) return {4'h3, s, 15'h0};
`endif
    case (m)
      3'd0: up = r > 16'h8000 || (r == 16'h8000 && t[0]);
      3'd1: up = 1'b0;
      3'd2: up = s && r != 0;
      3'd3: up = !s && r != 0;
      default: up = r >= 16'h8000;
    endcase
    if (t[14:0] == 15'h7F7F && (up || r >= 16'h8000)) return {4'h5, s, up ? 15'h7F80 : 15'h7F7F};
    return {2'b00, e == 8'h00 && r != 0, r != 0, t + {15'h0, up}};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic convert(input string tag, input logic [31:0] op, input logic [2:0] mode);
    logic [19:0] m;
    int n;
    m = model(op, mode);
    n = 0;
    @(negedge clk);
    instruction_enable = 1'b1;
    operand_a = op;
    rm = mode;
    result_ready = 1'b1;
    @(posedge clk);
    #1 instruction_enable = 1'b0;
    while (!result_valid && n < 8) begin
      @(posedge clk);
      #1 n++;
    end
    csr_m |= m[19:16];
    check({tag, " latency"}, n, 1);
    check({tag, " result"}, result, m[15:0]);
    check({tag, " fpcsr"}, fpcsr, csr_m);
  endtask

  task automatic clear_csr();
    @(negedge clk);
    fpcsr_clear = 1'b1;
    @(negedge clk);
    fpcsr_clear = 1'b0;
    csr_m = '0;
    check("clear", fpcsr, 0);
  endtask

  initial begin
    logic [31:0] ops[4];
    logic [15:0] got[$];
    logic [19:0] m;
    int sent;
    #12;
    check("reset result", result, 0);
    check("reset valid", result_valid, 0);
    check("reset fpcsr", fpcsr, 0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1 check("reset in_ready", in_ready, 1);

    convert("one rne", 32'h3F800000, 3'd0);
    convert("neg one", 32'hBF800000, 3'd0);
    convert("tie even", 32'h3F808000, 3'd0);
    convert("tie odd", 32'h3F818000, 3'd0);
    convert("tie rmm", 32'h3F808000, 3'd4);
    clear_csr();
    convert("ovf rne", 32'h7F7FFFFF, 3'd0);
    check("ovf csr 5", fpcsr, 4'h5);
    convert("ovf rtz", 32'h7F7FFFFF, 3'd1);
    convert("ovf neg rup", 32'hFF7FFFFF, 3'd3);
    clear_csr();
    convert("snan", 32'h7F800001, 3'd0);
    convert("qnan", 32'h7FC00000, 3'd0);
    convert("inf", 32'hFF800000, 3'd2);
    clear_csr();
    convert("sub rne", 32'h00000001, 3'd0);
    convert("sub rup", 32'h00000001, 3'd3);
    convert("neg zero", 32'h80000000, 3'd0);
    convert("reserved rm", 32'h3F818000, 3'd7);
    clear_csr();

    for (int i = 0; i < 4; i++) ops[i] = $urandom;
    sent = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      result_ready = cyc >= 4;
      instruction_enable = sent < 4;
      operand_a = ops[sent < 4 ? sent : 3];
      rm = 3'd0;
      #1;
      if (cyc == 2 || cyc == 3) begin
        m = model(ops[0], 3'd0);
        check("bp in_ready", in_ready, 0);
        check("bp accepted", sent, 2);
        check("bp hold", result, m[15:0]);
      end
      if (instruction_enable && in_ready) sent++;
      if (result_valid && result_ready) got.push_back(result);
    end
    instruction_enable = 1'b0;
    check("bp count", got.size(), 4);
    for (int i = 0; i < 4; i++) begin
      m = model(ops[i], 3'd0);
      csr_m |= m[19:16];
      if (i < got.size()) check("bp order", got[i], m[15:0]);
    end
    check("bp fpcsr", fpcsr, csr_m);

    for (int i = 0; i < 150; i++) begin
      logic [7:0] e;
      case ($urandom_range(0, 4))
        0: e = 8'h00;
        1: e = 8'hFF;
        2: e = 8'hFE;
        default: e = 8'($urandom);
      endcase
      convert("random", {1'($urandom), e, 23'($urandom)}, 3'($urandom_range(0, 7)));
      if (i % 25 == 24) clear_csr();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
